freq_meter: RTL

Gated frequency counter: the measuring counterpart of the clock-divider chain. It counts rising edges of an asynchronous input, such as a divided clock like clk1M or clk100k, over a fixed window of system-clock cycles. The block reports the count with a done pulse, so divider outputs can be checked in-system. It sits on the 50 MHz clk domain next to the divider blocks.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 23 ++
 rtl/freq_meter.sv | 110 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated frequency meter.
package freq_meter_pkg;

    localparam int DEFAULT_GATE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W       = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    // Width of the window down-counter; it only ever holds GATE_CYCLES-1.
    function automatic int gate_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer with a one-cycle rising-edge pulse on the
// synchronized copy of an asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    // sync_q[0]/[1] form the synchronizer; sync_q[2] is the edge-detect delay.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over a window of
// GATE_CYCLES clk cycles and reports the result with a done pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int                GATE_W    = gate_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    logic             rise;
    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0] edge_q;
    logic [CNT_W-1:0] edge_d;
    logic             acc_q;
    logic             acc_d;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .rise (rise)
    );

    // Edge count and overflow flag including this cycle's edge; the final
    // window cycle publishes these directly so its edge is not lost.
    always_comb begin
        edge_d = edge_q;
        acc_d  = acc_q;
        if (rise) begin
            if (&edge_q) begin
                acc_d = 1'b1;
            end else begin
                edge_d = edge_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            gate_q  <= '0;
            edge_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_MEASURE;
                        busy_q  <= 1'b1;
                        gate_q  <= GATE_LOAD;
                        edge_q  <= '0;
                        acc_q   <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (gate_q == '0) begin
                        count_q <= edge_d;
                        ovf_q   <= acc_d;
                        done_q  <= 1'b1;
                        // Reload unconditionally so continuous mode has no gap.
                        gate_q  <= GATE_LOAD;
                        edge_q  <= '0;
                        acc_q   <= 1'b0;
                        if (!cont) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gate_q <= gate_q - GATE_W'(1);
                        edge_q <= edge_d;
                        acc_q  <= acc_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
